// File: rtl/max7219_spi_ctrl.sv
// MAX7219 frame sequencer: runs the init ROM, then arbitrates host writes,
// intensity updates and digit refresh onto a shared two-byte SPI transmitter.
module max7219_spi_ctrl #(
    parameter int CS_GAP  = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_valid,
    input  logic [31:0] digits,
    input  logic [3:0]  intensity,
    input  logic        host_req,
    input  logic [3:0]  host_addr,
    input  logic [7:0]  host_data,
    output logic        spi_onoff,
    output logic [7:0]  spi_data,
    output logic        host_ack,
    output logic        busy,
    output logic        init_done,
    output logic        fault
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int GW = $clog2(CS_GAP) + 1;

    typedef enum logic [2:0] {INIT_SEL, SEL, IDLE, HI, LO, GAP} state_t;
    typedef enum logic [1:0] {K_INIT, K_HOST, K_INT, K_REF} kind_t;

    state_t        state, state_next;
    kind_t         kind, kind_next;
    logic [2:0]    init_step, init_step_next;
    logic [3:0]    addr, addr_next;
    logic [7:0]    data, data_next;
    logic [31:0]   snapshot, snapshot_next;
    logic [2:0]    ref_idx, ref_idx_next;
    logic          pass_active, pass_active_next;
    logic [3:0]    shadow, shadow_next;
    logic [TW-1:0] tmo_cnt, tmo_cnt_next;
    logic [GW-1:0] gap_cnt, gap_cnt_next;
    logic          spi_onoff_next, host_ack_next, init_done_next, fault_next;
    logic [7:0]    spi_data_next;
    logic          req_host, req_int, req_ref, timeout_hit, launch, abort;
    logic [3:0]    rom_addr;
    logic [7:0]    rom_data;

    assign busy        = (state != IDLE);
    assign req_host    = host_req & init_done;
    assign req_int     = (intensity != shadow);
    assign req_ref     = pass_active | (digits != snapshot);
    assign timeout_hit = (tmo_cnt == TW'(TIMEOUT - 1)) & ~spi_valid;

    always_comb begin
        rom_addr = 4'h0C;
        rom_data = 8'h01;
        case (init_step)
            3'd0: begin rom_addr = 4'h0C; rom_data = 8'h00; end
            3'd1: begin rom_addr = 4'h0F; rom_data = 8'h00; end
            3'd2: begin rom_addr = 4'h09; rom_data = 8'hFF; end
            3'd3: begin rom_addr = 4'h0B; rom_data = 8'h07; end
            3'd4: begin rom_addr = 4'h0A; rom_data = {4'h0, intensity}; end
            default: begin rom_addr = 4'h0C; rom_data = 8'h01; end
        endcase
    end

    always_comb begin
        state_next       = state;
        kind_next        = kind;
        init_step_next   = init_step;
        addr_next        = addr;
        data_next        = data;
        snapshot_next    = snapshot;
        ref_idx_next     = ref_idx;
        pass_active_next = pass_active;
        shadow_next      = shadow;
        tmo_cnt_next     = tmo_cnt;
        gap_cnt_next     = gap_cnt;
        spi_onoff_next   = spi_onoff;
        spi_data_next    = spi_data;
        host_ack_next    = 1'b0;
        init_done_next   = init_done;
        fault_next       = fault;
        launch           = 1'b0;
        abort            = 1'b0;

        case (state)
            INIT_SEL: begin
                addr_next = rom_addr;
                data_next = rom_data;
                kind_next = K_INIT;
                // The init intensity frame also counts as the shadowed value.
                if (init_step == 3'd4) shadow_next = intensity;
                launch = 1'b1;
            end
            SEL: begin
                if (req_host) begin
                    addr_next = host_addr;
                    data_next = host_data;
                    kind_next = K_HOST;
                    launch    = 1'b1;
                end else if (req_int) begin
                    addr_next   = 4'h0A;
                    data_next   = {4'h0, intensity};
                    shadow_next = intensity;
                    kind_next   = K_INT;
                    launch      = 1'b1;
                end else if (req_ref) begin
                    kind_next = K_REF;
                    launch    = 1'b1;
                    if (!pass_active) begin
                        snapshot_next    = digits;
                        ref_idx_next     = 3'd0;
                        pass_active_next = 1'b1;
                        addr_next        = 4'h1;
                        data_next        = {4'h0, digits[3:0]};
                    end else begin
                        addr_next = {1'b0, ref_idx} + 4'd1;
                        data_next = {4'h0, snapshot[{ref_idx, 2'b00} +: 4]};
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (req_host || req_int || req_ref) state_next = SEL;
            end
            HI: begin
                if (spi_valid) begin
                    spi_data_next = data;
                    tmo_cnt_next  = '0;
                    state_next    = LO;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt + TW'(1);
                end
            end
            LO: begin
                if (spi_valid) begin
                    spi_onoff_next = 1'b0;
                    host_ack_next  = (kind == K_HOST);
                    gap_cnt_next   = '0;
                    state_next     = GAP;
                    if (kind == K_INIT) init_step_next = init_step + 3'd1;
                    if (kind == K_REF) begin
                        if (ref_idx == 3'd7) pass_active_next = 1'b0;
                        ref_idx_next = ref_idx + 3'd1;
                    end
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt + TW'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GW'(CS_GAP - 1)) begin
                    if (init_done) begin
                        state_next = SEL;
                    end else if (init_step == 3'd6) begin
                        init_done_next = 1'b1;
                        state_next     = SEL;
                    end else begin
                        state_next = INIT_SEL;
                    end
                end else begin
                    gap_cnt_next = gap_cnt + GW'(1);
                end
            end
            default: state_next = INIT_SEL;
        endcase

        if (launch) begin
            spi_onoff_next = 1'b1;
            spi_data_next  = {4'h0, addr_next};
            tmo_cnt_next   = '0;
            state_next     = HI;
        end
        // Aborted frames leave step/index/request untouched so they are resent.
        if (abort) begin
            fault_next     = 1'b1;
            spi_onoff_next = 1'b0;
            gap_cnt_next   = '0;
            state_next     = GAP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= INIT_SEL;
            kind        <= K_INIT;
            init_step   <= '0;
            addr        <= '0;
            data        <= '0;
            snapshot    <= '0;
            ref_idx     <= '0;
            pass_active <= 1'b0;
            shadow      <= '0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
            spi_onoff   <= 1'b0;
            spi_data    <= '0;
            host_ack    <= 1'b0;
            init_done   <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_next;
            kind        <= kind_next;
            init_step   <= init_step_next;
            addr        <= addr_next;
            data        <= data_next;
            snapshot    <= snapshot_next;
            ref_idx     <= ref_idx_next;
            pass_active <= pass_active_next;
            shadow      <= shadow_next;
            tmo_cnt     <= tmo_cnt_next;
            gap_cnt     <= gap_cnt_next;
            spi_onoff   <= spi_onoff_next;
            spi_data    <= spi_data_next;
            host_ack    <= host_ack_next;
            init_done   <= init_done_next;
            fault       <= fault_next;
        end
    end
endmodule

// File: tb/tb_max7219_spi_ctrl.sv
// Testbench for max7219_spi_ctrl: a byte-level SPI responder, a frame
// monitor popping an expected-frame scoreboard, and directed scenarios.
module tb_max7219_spi_ctrl;
    localparam int CS_GAP   = 8;
    localparam int TIMEOUT  = 64;
    localparam int BYTE_CYC = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_valid;
    logic [31:0] digits;
    logic [3:0]  intensity;
    logic        host_req;
    logic [3:0]  host_addr;
    logic [7:0]  host_data;
    logic        spi_onoff;
    logic [7:0]  spi_data;
    logic        host_ack;
    logic        busy;
    logic        init_done;
    logic        fault;

    max7219_spi_ctrl #(.CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_valid (spi_valid),
        .digits    (digits),
        .intensity (intensity),
        .host_req  (host_req),
        .host_addr (host_addr),
        .host_data (host_data),
        .spi_onoff (spi_onoff),
        .spi_data  (spi_data),
        .host_ack  (host_ack),
        .busy      (busy),
        .init_done (init_done),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    int          cyc = 0;
    int          last_valid_cyc = 0;
    int          ack_count = 0;
    logic        suppress = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic push_init(input logic [3:0] inten);
        exp_q.push_back(16'h0C00);
        exp_q.push_back(16'h0F00);
        exp_q.push_back(16'h09FF);
        exp_q.push_back(16'h0B07);
        exp_q.push_back({12'h0A0, inten});
        exp_q.push_back(16'h0C01);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        chk(tag, {31'd0, (exp_q.size() == 0 && !busy)}, 1);
    endtask

    task automatic wait_ack(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (host_ack) break;
        end
        chk(tag, host_ack, 1);
        host_req = 1'b0;
    endtask

    task automatic wait_hi_data(input string tag, input logic [7:0] val, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (spi_onoff && spi_data == val) break;
        end
        chk(tag, {31'd0, (spi_onoff && spi_data == val)}, 1);
    endtask

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SPI responder: one valid pulse per BYTE_CYC cycles while onoff is high
    int   bcnt = 0;
    logic bno = 1'b0;
    initial begin
        spi_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            spi_valid = 1'b0;
            if (spi_onoff) begin
                if (bcnt == BYTE_CYC - 1) begin
                    bcnt = 0;
                    if (!(suppress && bno)) begin
                        spi_valid = 1'b1;
                        bno = ~bno;
                    end
                end else begin
                    bcnt++;
                end
            end else begin
                bcnt = 0;
                bno  = 1'b0;
            end
        end
    end

    // frame monitor and scoreboard consumer
    logic [7:0]  hi_byte = '0;
    logic        have_hi = 1'b0;
    logic        prev_onoff = 1'b0;
    logic        seen_frame = 1'b0;
    logic        gap_skip = 1'b0;
    int          low_cnt = 0;
    logic [15:0] want_frame;
    initial forever begin
        @(negedge clk);
        if (reset) gap_skip = 1'b1;
        if (host_ack) begin
            ack_count++;
            chk("ack_onoff_now", spi_onoff, 0);
            chk("ack_onoff_prev", prev_onoff, 1);
        end
        if (spi_onoff && spi_valid) begin
            last_valid_cyc = cyc;
            if (!have_hi) begin
                hi_byte = spi_data;
                have_hi = 1'b1;
            end else begin
                have_hi = 1'b0;
                want_frame = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
                chk("frame", {16'h0, hi_byte, spi_data}, {16'h0, want_frame});
                seen_frame = 1'b1;
            end
        end
        if (!spi_onoff) begin
            have_hi = 1'b0;
            low_cnt++;
        end else if (!prev_onoff) begin
            if (seen_frame && !gap_skip) chk("cs_gap_ge8", {31'd0, (low_cnt >= CS_GAP)}, 1);
            low_cnt  = 0;
            gap_skip = 1'b0;
        end
        prev_onoff = spi_onoff;
    end

    initial begin
        reset     = 1'b1;
        digits    = '0;
        intensity = 4'd5;
        host_req  = 1'b0;
        host_addr = '0;
        host_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_onoff", spi_onoff, 0);
        chk("rst_data", spi_data, 0);
        chk("rst_ack", host_ack, 0);
        chk("rst_busy", busy, 1);
        chk("rst_init_done", init_done, 0);
        chk("rst_fault", fault, 0);

        // init sequence
        push_init(4'd5);
        reset = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (init_done) break;
        end
        chk("init_done_rise", init_done, 1);
        chk("init_frames_before_done", exp_q.size(), 0);
        wait_idle("idle_after_init", 200);

        // refresh pass of 0x12
        digits = 32'h0000_0012;
        exp_q.push_back(16'h0102);
        exp_q.push_back(16'h0201);
        for (int k = 3; k <= 8; k++) exp_q.push_back({8'(k), 8'h00});
        wait_idle("refresh_12_done", 3000);
        chk("refresh_12_busy", busy, 0);

        // host write preempting after digit 3
        digits = 32'h8765_4321;
        for (int k = 1; k <= 3; k++) exp_q.push_back({8'(k), 8'(k)});
        wait_hi_data("digit3_seen", 8'h03, 1000);
        host_addr = 4'hF;
        host_data = 8'h01;
        host_req  = 1'b1;
        exp_q.push_back(16'h0F01);
        for (int k = 4; k <= 8; k++) exp_q.push_back({8'(k), 8'(k)});
        wait_ack("host_f01_ack", 1000);
        wait_idle("refresh_resume_done", 3000);
        chk("ack_count_1", ack_count, 1);

        // host beats intensity
        host_addr = 4'h1;
        host_data = 8'h55;
        host_req  = 1'b1;
        intensity = 4'd9;
        exp_q.push_back(16'h0155);
        exp_q.push_back(16'h0A09);
        wait_ack("host_155_ack", 1000);
        wait_idle("host_int_done", 1000);
        chk("ack_count_2", ack_count, 2);

        // timeout in LO, then retry
        suppress  = 1'b1;
        host_addr = 4'h2;
        host_data = 8'h33;
        host_req  = 1'b1;
        exp_q.push_back(16'h0233);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (fault) break;
        end
        chk("fault_set", fault, 1);
        chk("timeout_cycles", cyc - last_valid_cyc, 65);
        chk("timeout_onoff", spi_onoff, 0);
        chk("timeout_no_ack", ack_count, 2);
        suppress = 1'b0;
        wait_ack("retry_ack", 1000);
        wait_idle("retry_done", 1000);
        chk("ack_count_3", ack_count, 3);
        chk("fault_sticky", fault, 1);

        // reset mid-refresh
        digits = 32'h1111_1111;
        exp_q.push_back(16'h0101);
        wait_hi_data("digit2_seen", 8'h02, 1000);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_onoff", spi_onoff, 0);
        chk("midrst_init_done", init_done, 0);
        chk("midrst_busy", busy, 1);
        reset = 1'b0;
        push_init(4'd9);
        for (int k = 1; k <= 8; k++) exp_q.push_back({8'(k), 8'h01});
        wait_idle("reinit_refresh_done", 5000);
        chk("reinit_init_done", init_done, 1);
        chk("reinit_fault_clear", fault, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
